// File: rtl/sixteen_bit_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : sixteen_bit_subtractor
// Function : Multi-cycle subtractor that works one half-word at a time.
//            Operands are captured on start. The low half is produced in
//            LOW and the high half in HIGH. The high half takes either the
//            low-half borrow (full-width mode) or the captured borrowIn
//            (split mode). Results hold until the next operation replaces
//            them.
// Revision : 1.0  initial release
// ============================================================================
module sixteen_bit_subtractor #(
    parameter int HALF_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2*HALF_WIDTH-1:0] A,
    input  logic [2*HALF_WIDTH-1:0] B,
    input  logic                    borrowIn,
    input  logic                    split,
    output logic [2*HALF_WIDTH-1:0] D,
    output logic                    borrowLow,
    output logic                    borrowOut,
    output logic                    overflow,
    output logic                    busy,
    output logic                    done
);

    localparam int c_W   = 2 * HALF_WIDTH;
    localparam int c_MSB = HALF_WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                r_state;

    // Operands captured when the operation is accepted
    logic [c_W-1:0]        r_opA;
    logic [c_W-1:0]        r_opB;
    logic                  r_borrowIn;
    logic                  r_split;

    // Registered results and status
    logic [HALF_WIDTH-1:0] r_diffLo;
    logic [HALF_WIDTH-1:0] r_diffHi;
    logic                  r_borrowLow;
    logic                  r_borrowOut;
    logic                  r_overflow;
    logic                  r_busy;
    logic                  r_done;

    // Half-word views of the captured operands
    logic [HALF_WIDTH-1:0] w_aLo;
    logic [HALF_WIDTH-1:0] w_bLo;
    logic [HALF_WIDTH-1:0] w_aHi;
    logic [HALF_WIDTH-1:0] w_bHi;

    // One extra bit on each difference: its top bit is the borrow out
    logic [HALF_WIDTH:0]   w_lowDiff;
    logic [HALF_WIDTH:0]   w_highDiff;
    logic                  w_highBorrowIn;
    logic                  w_highOverflow;

    assign w_aLo = r_opA[HALF_WIDTH-1:0];
    assign w_bLo = r_opB[HALF_WIDTH-1:0];
    assign w_aHi = r_opA[c_W-1:HALF_WIDTH];
    assign w_bHi = r_opB[c_W-1:HALF_WIDTH];

    assign w_lowDiff = {1'b0, w_aLo} - {1'b0, w_bLo}
                     - {{HALF_WIDTH{1'b0}}, r_borrowIn};

    // Split mode keeps the halves independent: the high half takes the
    // captured borrowIn, not the low-half borrow.
    assign w_highBorrowIn = r_split ? r_borrowIn : r_borrowLow;

    assign w_highDiff = {1'b0, w_aHi} - {1'b0, w_bHi}
                      - {{HALF_WIDTH{1'b0}}, w_highBorrowIn};

    // Signed overflow: operand signs differ and the result sign leaves A's sign
    assign w_highOverflow = (w_aHi[c_MSB] ^ w_bHi[c_MSB])
                          & (w_highDiff[c_MSB] ^ w_aHi[c_MSB]);

    // Sequencer: capture operands, compute low then high half, then strobe done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_opA       <= '0;
            r_opB       <= '0;
            r_borrowIn  <= 1'b0;
            r_split     <= 1'b0;
            r_diffLo    <= '0;
            r_diffHi    <= '0;
            r_borrowLow <= 1'b0;
            r_borrowOut <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_opA      <= A;
                        r_opB      <= B;
                        r_borrowIn <= borrowIn;
                        r_split    <= split;
                        r_busy     <= 1'b1;
                        r_state    <= ST_LOW;
                    end else begin
                        r_busy     <= 1'b0;
                    end
                end
                ST_LOW: begin
                    r_diffLo    <= w_lowDiff[HALF_WIDTH-1:0];
                    r_borrowLow <= w_lowDiff[HALF_WIDTH];
                    r_busy      <= 1'b1;
                    r_done      <= 1'b0;
                    r_state     <= ST_HIGH;
                end
                ST_HIGH: begin
                    r_diffHi    <= w_highDiff[HALF_WIDTH-1:0];
                    r_borrowOut <= w_highDiff[HALF_WIDTH];
                    r_overflow  <= w_highOverflow;
                    r_busy      <= 1'b1;
                    r_done      <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign D         = {r_diffHi, r_diffLo};
    assign borrowLow = r_borrowLow;
    assign borrowOut = r_borrowOut;
    assign overflow  = r_overflow;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
